// File: rtl/seq_mult8_pkg.sv
// Shared definitions for the sequential 8x8 shift-and-add multiplier:
// FSM state encodings, operand/counter widths and the partial-product select.
package seq_mult8_pkg;

  localparam int N     = 8;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Partial-product row for the current multiplier bit.
  function automatic logic [N-1:0] pp_addend(input logic q_lsb, input logic [N-1:0] m);
    pp_addend = q_lsb ? m : 8'h00;
  endfunction

endpackage

// File: rtl/full_adder8b.sv
// 8-bit ripple-carry adder built from a chain of single-bit full adders.
module full_adder8b (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] sum_o,
  output logic       cout_o
);

  logic carry;

  // Ripple the carry from bit 0 up to bit 7.
  always_comb begin
    carry = cin_i;
    sum_o = 8'h00;
    for (int i = 0; i < 8; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry;
  end

endmodule

// File: rtl/seq_mult8.sv
// Sequential 8x8 unsigned shift-and-add multiplier: one adder pass per
// multiplier bit, 16-bit product published with a one-cycle done pulse.
module seq_mult8
  import seq_mult8_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [15:0] P,
  output logic        busy,
  output logic        done
);

  state_t           state_q;
  logic [N-1:0]     acc_q;
  logic [N-1:0]     q_q;
  logic [N-1:0]     m_q;
  logic [CNT_W-1:0] count_q;
  logic [15:0]      p_q;
  logic             busy_q;
  logic             done_q;

  logic [N-1:0]     addend_s;
  logic [N-1:0]     sum_s;
  logic             cout_s;
  logic [15:0]      shifted_s;

  assign addend_s  = pp_addend(q_q[0], m_q);
  // The adder carry becomes the new top bit of the accumulator after the shift.
  assign shifted_s = {cout_s, sum_s, q_q[N-1:1]};

  full_adder8b u_adder (
    .a_i    (acc_q),
    .b_i    (addend_s),
    .cin_i  (1'b0),
    .sum_o  (sum_s),
    .cout_o (cout_s)
  );

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= 8'h00;
      q_q     <= 8'h00;
      m_q     <= 8'h00;
      count_q <= 3'd0;
      p_q     <= 16'h0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            m_q     <= A;
            q_q     <= B;
            acc_q   <= 8'h00;
            count_q <= 3'd0;
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          {acc_q, q_q} <= shifted_s;
          count_q      <= count_q + 3'd1;
          if (count_q == CNT_W'(N - 1)) begin
            p_q     <= shifted_s;
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign P    = p_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_seq_mult8.sv
// Directed and random checks of seq_mult8: timing of busy/done, product
// values, ignored start, operand capture, start held high and async reset.
module tb_seq_mult8;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [15:0] P;
  logic        busy;
  logic        done;

  int total;
  int bad;
  int done_seen;

  seq_mult8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .P     (P),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done) done_seen <= done_seen + 1;
  end

  // Launch one multiply and return the product at the done cycle, then step into IDLE.
  task automatic run_mult(input logic [7:0] a, input logic [7:0] b,
                          output logic [15:0] p, output bit timed_out);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    timed_out = !done;
    p = P;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; A = 8'h00; B = 8'h00;
    @(negedge clk);
    total++;
    if (P !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset: P=%h busy=%b done=%b, want P=0000 busy=0 done=0", P, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    @(negedge clk);
    A = 8'h0D; B = 8'h0B; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      total++;
      if (busy !== 1'b1 || done !== 1'b0 || P !== 16'h0000) begin
        bad++;
        $display("FAIL basic_run k=%0d: busy=%b done=%b P=%h, want busy=1 done=0 P=0000", k, busy, done, P);
      end
      if (k < 7) @(negedge clk);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b1 || P !== 16'h008F) begin
      bad++;
      $display("FAIL basic_done: busy=%b done=%b P=%h, want busy=0 done=1 P=008F", busy, done, P);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || P !== 16'h008F) begin
      bad++;
      $display("FAIL basic_after: busy=%b done=%b P=%h, want busy=0 done=0 P=008F", busy, done, P);
    end
  endtask

  task automatic test_vectors();
    logic [7:0]  va [3] = '{8'hFF, 8'h00, 8'h01};
    logic [7:0]  vb [3] = '{8'hFF, 8'hFF, 8'h01};
    logic [15:0] vp [3] = '{16'hFE01, 16'h0000, 16'h0001};
    logic [15:0] p;
    bit to;
    for (int i = 0; i < 3; i++) begin
      run_mult(va[i], vb[i], p, to);
      total++;
      if (to || p !== vp[i]) begin
        bad++;
        $display("FAIL vector %h*%h: P=%h timeout=%b, want %h", va[i], vb[i], p, to, vp[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    @(negedge clk);
    A = 8'h80; B = 8'h02; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    A = 8'h03; B = 8'h03; start = 1'b1;
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    start = 1'b0;
    total++;
    if (done !== 1'b1 || P !== 16'h0100) begin
      bad++;
      $display("FAIL ignore_done: done=%b P=%h, want done=1 P=0100", done, P);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || P !== 16'h0100) begin
      bad++;
      $display("FAIL ignore_after: busy=%b P=%h, want busy=0 P=0100", busy, P);
    end
  endtask

  task automatic test_hold_start();
    int first_done;
    int second_done;
    first_done = -1; second_done = -1;
    @(negedge clk);
    A = 8'h21; B = 8'h03; start = 1'b1;
    @(negedge clk);
    A = 8'h55; B = 8'h55;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done && first_done < 0) begin
        first_done = i;
        total++;
        if (P !== 16'h0063) begin
          bad++;
          $display("FAIL hold_first: P=%h, want 0063", P);
        end
      end else if (done && second_done < 0) begin
        second_done = i;
        start = 1'b0;
        total++;
        if (P !== 16'h1C39) begin
          bad++;
          $display("FAIL hold_second: P=%h, want 1C39", P);
        end
      end
    end
    start = 1'b0;
    total++;
    if (first_done != 8 || second_done != 18) begin
      bad++;
      $display("FAIL hold_spacing: done at %0d,%0d, want 8,18", first_done, second_done);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    logic [15:0] p;
    bit to;
    @(negedge clk);
    A = 8'h12; B = 8'h34; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (P !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: P=%h busy=%b done=%b, want 0000 0 0", P, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_mult(8'h12, 8'h34, p, to);
    total++;
    if (to || p !== 16'h03A8) begin
      bad++;
      $display("FAIL after_reset: P=%h timeout=%b, want 03A8", p, to);
    end
  endtask

  task automatic test_random();
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    logic [15:0] exp;
    bit to;
    int d0;
    int accepted;
    int errs;
    errs = 0;
    accepted = 0;
    d0 = done_seen;
    for (int i = 0; i < 200; i++) begin
      a = 8'($urandom_range(255));
      b = 8'($urandom_range(255));
      exp = 16'(a) * 16'(b);
      run_mult(a, b, p, to);
      accepted++;
      total++;
      if (to || p !== exp) begin
        bad++;
        errs++;
        if (errs < 5) $display("FAIL random %h*%h: P=%h timeout=%b, want %h", a, b, p, to, exp);
      end
    end
    total++;
    if (done_seen - d0 != accepted) begin
      bad++;
      $display("FAIL done_count: got %0d pulses, want %0d", done_seen - d0, accepted);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    done_seen = 0;
    test_reset();
    test_basic();
    test_vectors();
    test_ignore_start();
    test_hold_start();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
